// File: rtl/main_memory_pkg.sv
// Shared types and constants for the paged main memory.
package definesPkg;

    localparam int unsigned NUM_PAGES      = 2;
    localparam int unsigned WORDS_PER_PAGE = 256;
    localparam int unsigned DEPTH          = NUM_PAGES * WORDS_PER_PAGE;
    localparam int unsigned INDEX_W        = $clog2(DEPTH);

    typedef struct packed {
        logic [0:0] Page_reference;
        logic [7:0] Address_code;
    } Taddress;

    typedef struct packed {
        logic [31:0] Data;
    } Tdata_sb;

    typedef enum logic [1:0] {
        INVALID   = 2'b00,
        SHARED    = 2'b01,
        EXCLUSIVE = 2'b10,
        MODIFIED  = 2'b11
    } Tmesi_state;

    // Page bit is the MSB, so the two pages are contiguous in the flat array.
    function automatic logic [INDEX_W-1:0] flat_index(input Taddress a);
        return {a.Page_reference, a.Address_code};
    endfunction

endpackage

// File: rtl/main_memory.sv
// Two-page, 256-word-per-page memory with a MESI tag per word.
// Registered, write-first read port; synchronous reset reinitialises every entry.
// Optional macro MAIN_MEMORY_INIT_PATTERN_EN: reset loads Data = INIT_BASE + flat index
// instead of zero.
module main_memory
    import definesPkg::*;
#(
    parameter logic [31:0] INIT_BASE = 32'h0000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  Taddress    addr,
    input  Tdata_sb    wdata,
    input  logic       we,
    input  Tmesi_state mesi_state_in,
    output Tdata_sb    rdata,
    output Tmesi_state mesi_state_out
);

    Tdata_sb    mem_data_q [DEPTH];
    Tmesi_state mem_tag_q  [DEPTH];

    Tdata_sb    rdata_d, rdata_q;
    Tmesi_state mesi_d,  mesi_q;

    logic [INDEX_W-1:0] idx;

    assign idx = flat_index(addr);

`ifndef MAIN_MEMORY_INIT_PATTERN_EN
    logic unused_init_base;
    assign unused_init_base = ^INIT_BASE;
`endif

    // Storage array: reset reloads every entry, otherwise a single-word write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
`ifdef MAIN_MEMORY_INIT_PATTERN_EN
                mem_data_q[i] <= Tdata_sb'(INIT_BASE + 32'(i));
`else
                mem_data_q[i] <= '0;
`endif
                mem_tag_q[i] <= INVALID;
            end
        end else if (we) begin
            mem_data_q[idx] <= wdata;
            mem_tag_q[idx]  <= mesi_state_in;
        end
    end

    // Read data selection; a write to the read address bypasses the array (write-first).
    always_comb begin
        rdata_d = mem_data_q[idx];
        mesi_d  = mem_tag_q[idx];
        if (we) begin
            rdata_d = wdata;
            mesi_d  = mesi_state_in;
        end
    end

    // Output registers: one-cycle read latency, cleared during reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= '0;
            mesi_q  <= INVALID;
        end else begin
            rdata_q <= rdata_d;
            mesi_q  <= mesi_d;
        end
    end

    assign rdata          = rdata_q;
    assign mesi_state_out = mesi_q;

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench for main_memory: stimulus pushes expected read results from an
// array-based reference model; a negedge monitor pops and compares.
module tb_main_memory;
    import definesPkg::*;

    localparam logic [31:0] TB_INIT_BASE = 32'h0000_0000;
    localparam int unsigned NWORDS = 512;

    logic       clk = 1'b0;
    logic       reset;
    Taddress    addr;
    Tdata_sb    wdata;
    logic       we;
    Tmesi_state mesi_state_in;
    Tdata_sb    rdata;
    Tmesi_state mesi_state_out;

    main_memory #(.INIT_BASE(TB_INIT_BASE)) dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .mesi_state_in (mesi_state_in),
        .rdata         (rdata),
        .mesi_state_out(mesi_state_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  tag;
        int unsigned seq;
        int unsigned where;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: one word and one tag per flat address.
    logic [31:0] m_data [NWORDS];
    logic [1:0]  m_tag  [NWORDS];

    int unsigned n_vec  = 0;
    int unsigned n_err  = 0;
    int unsigned seq_no = 0;

    function automatic logic [31:0] init_word(input int unsigned i);
`ifdef MAIN_MEMORY_INIT_PATTERN_EN
        return TB_INIT_BASE + i;
`else
        return 32'h0 + 0 * i;
`endif
    endfunction

    // One clock: drive inputs away from the edge, then record what the edge must produce.
    task automatic step(input logic rst, input int unsigned a, input logic w,
                        input logic [31:0] d, input logic [1:0] t);
        exp_t e;
        @(negedge clk);
        reset         = rst;
        addr          = Taddress'(a[8:0]);
        we            = w;
        wdata         = Tdata_sb'(d);
        mesi_state_in = Tmesi_state'(t);
        @(posedge clk);
        e.seq   = seq_no;
        e.where = a;
        seq_no++;
        if (rst) begin
            e.data = 32'h0;
            e.tag  = 2'b00;
            for (int i = 0; i < NWORDS; i++) begin
                m_data[i] = init_word(i);
                m_tag[i]  = 2'b00;
            end
        end else begin
            if (w) begin
                m_data[a] = d;
                m_tag[a]  = t;
            end
            e.data = m_data[a];
            e.tag  = m_tag[a];
        end
        exp_q.push_back(e);
    endtask

    task automatic rd(input int unsigned a);
        step(1'b0, a, 1'b0, $urandom, 2'($urandom_range(0, 3)));
    endtask

    // Monitor: outputs are stable between edges, so compare on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rdata !== e.data || mesi_state_out !== e.tag) begin
                n_err++;
                $display("FAIL read seq %0d addr %03h: got data %h tag %0d, expected data %h tag %0d",
                         e.seq, e.where, rdata, mesi_state_out, e.data, e.tag);
            end
        end
    end

    initial begin
        int unsigned hot [4];
        reset = 1'b1; addr = '0; we = 1'b0; wdata = '0; mesi_state_in = INVALID;

        // Reset, with a write attempt that must be ignored.
        step(1'b1, 0, 1'b0, 32'h0, 2'b00);
        step(1'b1, 9'h033, 1'b1, 32'hFFFF_FFFF, 2'b11);

        // Sweep every address of both pages.
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 256; c++)
                rd(p * 256 + c);

        // Write then read back.
        step(1'b0, 9'h010, 1'b1, 32'hDEAD_BEEF, 2'b11);
        rd(9'h000);
        rd(9'h010);

        // Same-edge write and read at the last address.
        step(1'b0, 9'h1FF, 1'b1, 32'h1234_5678, 2'b01);
        rd(9'h1FF);

        // Mid-stream reset wipes a written entry.
        step(1'b0, 9'h020, 1'b1, 32'hCAFE_F00D, 2'b10);
        step(1'b1, 9'h020, 1'b1, 32'h5555_AAAA, 2'b11);
        rd(9'h020);
        rd(9'h180);

        // A write must not disturb its neighbours.
        step(1'b0, 9'h001, 1'b1, 32'hA5A5_0001, 2'b10);
        rd(9'h000);
        rd(9'h002);
        rd(9'h001);

        // Randomised traffic, biased toward a few hot addresses for read-after-write.
        for (int i = 0; i < 4; i++) hot[i] = $urandom_range(0, NWORDS - 1);
        hot[0] = 9'h0FF;
        for (int i = 0; i < 2000; i++) begin
            int unsigned a;
            logic        w, r;
            a = ($urandom_range(0, 2) == 0) ? $urandom_range(0, NWORDS - 1)
                                            : hot[$urandom_range(0, 3)];
            w = ($urandom_range(0, 9) < 4);
            r = ($urandom_range(0, 199) == 0);
            step(r, a, w, $urandom, 2'($urandom_range(0, 3)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected results left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/main_memory.md
MAIN_MEMORY -- requirements
Module: main_memory

Interface
REQ-001 Parameter INIT_BASE, default 32'h0000_0000; offset added to the reset init pattern.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 addr  input  Taddress (9)  fields Page_reference[0:0] (page), Address_code[7:0] (word within page).
REQ-005 wdata  input  Tdata_sb (32)  write word; field Data[31:0].
REQ-006 we  input  1  write enable for the current cycle.
REQ-007 mesi_state_in  input  Tmesi_state (2)  MESI tag stored with a write.
REQ-008 rdata  output  Tdata_sb (32)  registered read word.
REQ-009 mesi_state_out  output  Tmesi_state (2)  registered MESI tag of the read word.

Function
REQ-010 Storage SHALL be 2 pages x 256 words; each entry holds Data[31:0] plus a Tmesi_state tag; flat index = {Page_reference, Address_code}.
REQ-011 Every non-reset cycle, the entry at addr SHALL be read; rdata and mesi_state_out SHALL update at that edge (1-cycle latency) and hold until the next edge.
REQ-012 With we=1 on a non-reset edge, the entry at addr SHALL take wdata.Data and mesi_state_in.
REQ-013 Write and read of the same address on the same edge SHALL be write-first: outputs show the newly written data and tag.
REQ-014 All 512 addresses, including Address_code 8'hFF and page 1, SHALL be accessible; no wrap-around or out-of-range case exists.
REQ-015 we SHALL not affect entries other than addr; stored tags SHALL change only through writes or reset.
REQ-016 There is no handshake: a new address is accepted every cycle.

Reset
REQ-017 While reset=1 at an edge: rdata SHALL be 32'h0, mesi_state_out SHALL be INVALID, and we SHALL be ignored.
REQ-018 Reset SHALL initialise every entry's tag to INVALID and its Data per REQ-020.
REQ-019 Reset asserted mid-stream SHALL take effect at the next edge; the first read after deassertion SHALL return the initialised contents.

Configuration
REQ-020 With macro MAIN_MEMORY_INIT_PATTERN_EN defined, reset SHALL load Data = INIT_BASE + zero-extended flat index; without it, reset SHALL load Data = 32'h0 and INIT_BASE SHALL be unused.

Structure
REQ-021 Package definesPkg SHALL hold Taddress (packed struct Page_reference, Address_code), Tdata_sb (packed struct Data[31:0]), Tmesi_state (enum INVALID=2'b00, SHARED=2'b01, EXCLUSIVE=2'b10, MODIFIED=2'b11), and constants NUM_PAGES=2 and WORDS_PER_PAGE=256.
REQ-022 The block SHALL be a single module main_memory with no sub-modules.

Verification
REQ-023 Macro defined, INIT_BASE=0: reset, then sweep page 0/1 and Address_code 0..255 on consecutive edges -> rdata.Data equals the previous cycle's flat index (e.g. page1/0x05 -> 32'h0000_0105) and mesi_state_out is INVALID.
REQ-024 Write page0/0x10 Data=32'hDEAD_BEEF with MODIFIED, then read it back -> 32'hDEAD_BEEF and MODIFIED one cycle after the read address.
REQ-025 Write and read page1/0xFF on the same edge with 32'h1234_5678 and SHARED -> outputs show 32'h1234_5678 and SHARED at that edge.
REQ-026 Write page0/0x20, assert reset for one cycle, then read page0/0x20 -> the init pattern and INVALID; during reset rdata is 0.
REQ-027 Macro undefined: reset, then read page1/0x80 -> 32'h0 and INVALID.
REQ-028 Write page0/0x01 with EXCLUSIVE, then read page0/0x00 and page0/0x02 -> both unchanged.
